// File: rtl/rgb_led_sequencer.sv
// rgb_led_sequencer: four-step RGB LED colour sequencer.
// Each step shows colorN for durationN ticks of TICK_DIV clocks; zero-duration steps are skipped.
// Optional build macro SEQ_DONE_IRQ_EN adds a one-clock seq_done_o pulse on every sequence wrap.
module rgb_led_sequencer #(
  parameter int unsigned TICK_DIV = 12000
) (
  input  logic        WBs_CLK_i,
  input  logic        WBs_RSTn_i,
  input  logic [2:0]  color0,
  input  logic [2:0]  color1,
  input  logic [2:0]  color2,
  input  logic [2:0]  color3,
  input  logic [11:0] duration0,
  input  logic [11:0] duration1,
  input  logic [11:0] duration2,
  input  logic [11:0] duration3,
  output logic        redled,
  output logic        greenled,
  output logic        blueled,
  output logic [1:0]  step_o,
  output logic        running_o,
  output logic        seq_done_o
);

  localparam int unsigned PW = 16;
  localparam int unsigned DW = 12;
  localparam int unsigned SW = 2;
  localparam int unsigned NSTEP = 4;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [DW-1:0] remaining;

  logic [DW-1:0] dur [NSTEP];
  logic [2:0]    col [NSTEP];

  logic          any_nz;
  logic [SW-1:0] first_idx;
  logic          next_found;
  logic [SW-1:0] next_idx;
  logic          tick;

  assign dur[0] = duration0;
  assign dur[1] = duration1;
  assign dur[2] = duration2;
  assign dur[3] = duration3;
  assign col[0] = color0;
  assign col[1] = color1;
  assign col[2] = color2;
  assign col[3] = color3;

  assign running_o = (state == RUN);
  assign tick      = (presc == PRESC_LAST);

  // Step selection: lowest nonzero step for entry, first nonzero after the current one for step end
  always_comb begin
    any_nz     = 1'b0;
    first_idx  = '0;
    next_found = 1'b0;
    next_idx   = step_o;
    for (int i = NSTEP - 1; i >= 0; i--) begin
      if (dur[i] != '0) begin
        any_nz    = 1'b1;
        first_idx = SW'(i);
      end
    end
    // Searched backwards so the nearest candidate (step+1 first, step itself last) wins
    for (int k = NSTEP; k >= 1; k--) begin
      if (dur[SW'(step_o + SW'(k))] != '0) begin
        next_found = 1'b1;
        next_idx   = SW'(step_o + SW'(k));
      end
    end
  end

  // Sequencer state, prescaler, remaining-tick counter, step index and LED drives
  always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
    if (!WBs_RSTn_i) begin
      state     <= IDLE;
      presc     <= '0;
      remaining <= '0;
      step_o    <= '0;
      redled    <= 1'b0;
      greenled  <= 1'b0;
      blueled   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_nz) begin
            state     <= RUN;
            step_o    <= first_idx;
            remaining <= dur[first_idx];
            presc     <= '0;
          end
        end
        RUN: begin
          if (tick) begin
            presc <= '0;
            if (remaining == DW'(1)) begin
              if (next_found) begin
                step_o    <= next_idx;
                remaining <= dur[next_idx];
              end else begin
                state     <= IDLE;
                remaining <= '0;
              end
            end else begin
              remaining <= remaining - DW'(1);
            end
          end else begin
            presc <= presc + PW'(1);
          end
        end
        default: state <= IDLE;
      endcase
      // LEDs follow the active step's colour one clock later; dark outside RUN
      if (state == RUN) begin
        {blueled, greenled, redled} <= col[step_o];
      end else begin
        {blueled, greenled, redled} <= 3'b000;
      end
    end
  end

`ifdef SEQ_DONE_IRQ_EN
  // Wrap pulse: a step end that moves to an index not above the ending step
  always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
    if (!WBs_RSTn_i) begin
      seq_done_o <= 1'b0;
    end else begin
      seq_done_o <= (state == RUN) && tick && (remaining == DW'(1)) &&
                    next_found && (next_idx <= step_o);
    end
  end
`else
  assign seq_done_o = 1'b0;
`endif

endmodule

// File: tb/tb_rgb_led_sequencer.sv
// Directed self-checking bench for rgb_led_sequencer with TICK_DIV=4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_rgb_led_sequencer;

  localparam int unsigned TICK_DIV = 4;
`ifdef SEQ_DONE_IRQ_EN
  localparam logic IRQ = 1'b1;
`else
  localparam logic IRQ = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [2:0]  color0, color1, color2, color3;
  logic [11:0] duration0, duration1, duration2, duration3;
  logic        redled, greenled, blueled;
  logic [1:0]  step_o;
  logic        running_o;
  logic        seq_done_o;
  logic [2:0]  leds;

  int n_cmp = 0;
  int n_err = 0;

  assign leds = {blueled, greenled, redled};

  rgb_led_sequencer #(.TICK_DIV(TICK_DIV)) dut (
    .WBs_CLK_i  (clk),
    .WBs_RSTn_i (rst_n),
    .color0     (color0),
    .color1     (color1),
    .color2     (color2),
    .color3     (color3),
    .duration0  (duration0),
    .duration1  (duration1),
    .duration2  (duration2),
    .duration3  (duration3),
    .redled     (redled),
    .greenled   (greenled),
    .blueled    (blueled),
    .step_o     (step_o),
    .running_o  (running_o),
    .seq_done_o (seq_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_dur(input logic [11:0] d0, input logic [11:0] d1,
                         input logic [11:0] d2, input logic [11:0] d3);
    duration0 = d0; duration1 = d1; duration2 = d2; duration3 = d3;
  endtask

  initial begin
    rst_n = 1'b0;
    color0 = 3'd1; color1 = 3'd2; color2 = 3'd3; color3 = 3'd4;
    set_dur(12'd0, 12'd0, 12'd0, 12'd0);
    #1;
    chk("rst_running", 12'(running_o), 12'd0);
    chk("rst_step", 12'(step_o), 12'd0);
    chk("rst_leds", 12'(leds), 12'd0);
    chk("rst_done", 12'(seq_done_o), 12'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    chk("idle_running", 12'(running_o), 12'd0);
    chk("idle_leds", 12'(leds), 12'd0);

    // Durations 2,3,0,1: red 8, green 12, step 2 skipped, blue 4, wrap to step 0
    set_dur(12'd2, 12'd3, 12'd0, 12'd1);        // s0
    cyc(1);                                     // s1
    chk("seq_run", 12'(running_o), 12'd1);
    chk("seq_s1_step", 12'(step_o), 12'd0);
    chk("seq_s1_leds", 12'(leds), 12'd0);
    cyc(1);                                     // s2
    chk("seq_s2_leds", 12'(leds), 12'd1);
    cyc(6);                                     // s8
    chk("seq_s8_step", 12'(step_o), 12'd0);
    chk("seq_s8_leds", 12'(leds), 12'd1);
    cyc(1);                                     // s9
    chk("seq_s9_step", 12'(step_o), 12'd1);
    chk("seq_s9_leds", 12'(leds), 12'd1);
    chk("seq_s9_done", 12'(seq_done_o), 12'd0);
    cyc(1);                                     // s10
    chk("seq_s10_leds", 12'(leds), 12'd2);
    cyc(11);                                    // s21
    chk("seq_s21_step", 12'(step_o), 12'd3);
    chk("seq_s21_leds", 12'(leds), 12'd2);
    cyc(1);                                     // s22
    chk("seq_s22_leds", 12'(leds), 12'd4);
    cyc(3);                                     // s25
    chk("seq_s25_step", 12'(step_o), 12'd0);
    chk("seq_s25_leds", 12'(leds), 12'd4);
    chk("seq_s25_done", 12'(seq_done_o), 12'(IRQ));
    cyc(1);                                     // s26
    chk("seq_s26_leds", 12'(leds), 12'd1);
    chk("seq_s26_done", 12'(seq_done_o), 12'd0);
    cyc(9);                                     // s35, mid step 1
    chk("seq_s35_step", 12'(step_o), 12'd1);

    // One-clock reset pulse mid step 1
    rst_n = 1'b0;
    #1;
    chk("arst_running", 12'(running_o), 12'd0);
    chk("arst_step", 12'(step_o), 12'd0);
    chk("arst_leds", 12'(leds), 12'd0);
    chk("arst_done", 12'(seq_done_o), 12'd0);
    cyc(1);
    rst_n = 1'b1;                               // r0
    cyc(1);                                     // r1
    chk("arst_r1_running", 12'(running_o), 12'd1);
    chk("arst_r1_step", 12'(step_o), 12'd0);
    cyc(7);                                     // r8
    chk("arst_r8_step", 12'(step_o), 12'd0);
    cyc(1);                                     // r9
    chk("arst_r9_step", 12'(step_o), 12'd1);

    // Mid-step duration change keeps the current count
    @(negedge clk);
    rst_n = 1'b0;
    set_dur(12'd10, 12'd1, 12'd0, 12'd0);
    cyc(1);
    rst_n = 1'b1;                               // s0
    cyc(1);                                     // s1
    chk("dchg_s1_step", 12'(step_o), 12'd0);
    cyc(7);                                     // s8
    duration0 = 12'd2;
    cyc(32);                                    // s40
    chk("dchg_s40_step", 12'(step_o), 12'd0);
    cyc(1);                                     // s41
    chk("dchg_s41_step", 12'(step_o), 12'd1);
    chk("dchg_s41_done", 12'(seq_done_o), 12'd0);
    cyc(3);                                     // s44
    chk("dchg_s44_step", 12'(step_o), 12'd1);
    cyc(1);                                     // s45
    chk("dchg_s45_step", 12'(step_o), 12'd0);
    chk("dchg_s45_done", 12'(seq_done_o), 12'(IRQ));
    cyc(7);                                     // s52
    chk("dchg_s52_step", 12'(step_o), 12'd0);
    cyc(1);                                     // s53
    chk("dchg_s53_step", 12'(step_o), 12'd1);

    // Single active step 1 repeating: wrap pulse every 12 clocks
    @(negedge clk);
    rst_n = 1'b0;
    set_dur(12'd0, 12'd3, 12'd0, 12'd0);
    cyc(1);
    rst_n = 1'b1;                               // s0
    cyc(1);                                     // s1
    chk("rep_s1_step", 12'(step_o), 12'd1);
    chk("rep_s1_done", 12'(seq_done_o), 12'd0);
    cyc(12);                                    // s13
    chk("rep_s13_done", 12'(seq_done_o), 12'(IRQ));
    cyc(1);                                     // s14
    chk("rep_s14_done", 12'(seq_done_o), 12'd0);
    cyc(11);                                    // s25
    chk("rep_s25_done", 12'(seq_done_o), 12'(IRQ));

    // Clear all durations mid step 3: step finishes, then IDLE
    @(negedge clk);
    rst_n = 1'b0;
    color3 = 3'd5;
    set_dur(12'd0, 12'd0, 12'd0, 12'd6);
    cyc(1);
    rst_n = 1'b1;                               // s0
    cyc(1);                                     // s1
    chk("clr_s1_step", 12'(step_o), 12'd3);
    cyc(1);                                     // s2
    chk("clr_s2_leds", 12'(leds), 12'd5);
    cyc(8);                                     // s10
    set_dur(12'd0, 12'd0, 12'd0, 12'd0);
    cyc(14);                                    // s24
    chk("clr_s24_running", 12'(running_o), 12'd1);
    chk("clr_s24_step", 12'(step_o), 12'd3);
    cyc(1);                                     // s25
    chk("clr_s25_running", 12'(running_o), 12'd0);
    chk("clr_s25_step", 12'(step_o), 12'd3);
    chk("clr_s25_leds", 12'(leds), 12'd5);
    chk("clr_s25_done", 12'(seq_done_o), 12'd0);
    cyc(1);                                     // s26
    chk("clr_s26_leds", 12'(leds), 12'd0);
    cyc(14);                                    // s40
    chk("clr_s40_running", 12'(running_o), 12'd0);
    chk("clr_s40_leds", 12'(leds), 12'd0);
    chk("clr_s40_step", 12'(step_o), 12'd3);

    // From IDLE, duration2=5 alone: enter step 2, hold 20 clocks, repeat
    color2 = 3'd3;
    duration2 = 12'd5;                          // s40
    cyc(1);                                     // s41
    chk("one_s41_running", 12'(running_o), 12'd1);
    chk("one_s41_step", 12'(step_o), 12'd2);
    chk("one_s41_leds", 12'(leds), 12'd0);
    cyc(1);                                     // s42
    chk("one_s42_leds", 12'(leds), 12'd3);
    cyc(3);                                     // s45
    color2 = 3'd6;
    cyc(1);                                     // s46
    chk("one_s46_leds", 12'(leds), 12'd6);
    cyc(14);                                    // s60
    chk("one_s60_step", 12'(step_o), 12'd2);
    chk("one_s60_done", 12'(seq_done_o), 12'd0);
    cyc(1);                                     // s61
    chk("one_s61_step", 12'(step_o), 12'd2);
    chk("one_s61_done", 12'(seq_done_o), 12'(IRQ));
    cyc(1);                                     // s62
    chk("one_s62_done", 12'(seq_done_o), 12'd0);
    chk("one_s62_running", 12'(running_o), 12'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rgb_led_sequencer.md
RGB_LED_SEQUENCER -- requirements
Module: rgb_led_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 12000: clock cycles per duration unit (1 ms at 12 MHz); legal range 2..65535.
REQ-002 SHALL have port WBs_CLK_i, input, 1: the single clock.
REQ-003 SHALL have port WBs_RSTn_i, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have ports color0..color3, input, 3 each: step colour; bit0 red, bit1 green, bit2 blue.
REQ-005 SHALL have ports duration0..duration3, input, 12 each: step length in ticks; 0 means skip the step.
REQ-006 SHALL have ports redled, greenled, blueled, output, 1 each: registered LED drives, 1 = on.
REQ-007 SHALL have port step_o, output, 2: index of the active step.
REQ-008 SHALL have port running_o, output, 1: 1 when in RUN.
REQ-009 SHALL have port seq_done_o, output, 1: sequence-complete pulse.

Function
REQ-010 SHALL implement two states: IDLE and RUN.
REQ-011 IDLE SHALL go to RUN when any durationN != 0; the entered step is the lowest N with durationN != 0; entry takes 1 clock.
REQ-012 On step entry, the block SHALL load a 12-bit remaining counter from the live durationN and clear the 16-bit prescaler to 0.
REQ-013 The prescaler SHALL count 0..TICK_DIV-1 and wrap; the tick pulse SHALL assert in the cycle the prescaler equals TICK_DIV-1.
REQ-014 On each tick, remaining SHALL decrement; a tick with remaining==1 SHALL end the step, so a step lasts exactly durationN*TICK_DIV clocks.
REQ-015 At step end, the next step SHALL be the first of step+1, step+2, step+3, step (mod 4) with live duration != 0; if none is nonzero, the block SHALL go to IDLE.
REQ-016 A durationN change mid-step SHALL NOT alter the current step's remaining count; it takes effect at the next entry of that step.
REQ-017 If all durations become 0 mid-step, the current step SHALL complete, then go to IDLE.
REQ-018 LED outputs SHALL equal colorN[step_o] registered, 1-cycle latency from state and colour; a live colour change SHALL be visible within 1 clock.
REQ-019 In IDLE, LED outputs SHALL be 0, step_o SHALL hold its last value, and running_o SHALL be 0.
REQ-020 The remaining counter SHALL NOT underflow; remaining==0 SHALL NOT occur in RUN.

Reset
REQ-021 WBs_RSTn_i low SHALL asynchronously force state IDLE, prescaler 0, remaining 0, step_o 0, all LEDs 0, running_o 0, seq_done_o 0.
REQ-022 Reset asserted mid-step SHALL abort immediately; after release, operation SHALL restart per REQ-011 with no residual count.

Configuration
REQ-023 Macro SEQ_DONE_IRQ_EN defined: seq_done_o SHALL pulse high for exactly 1 clock in the cycle a step-end transition selects a next step whose index is <= the ending step (wrap, including a single active step repeating).
REQ-024 Macro SEQ_DONE_IRQ_EN undefined: seq_done_o SHALL be constant 0 and no detection logic SHALL be built.

Verification (TICK_DIV=4)
REQ-025 Reset, then durations 2,3,0,1 with colours 1,2,3,4 -> red on for 8 clk, green for 12, step 2 skipped, blue for 4, then back to step 0; pattern repeats.
REQ-026 All durations 0 -> running_o=0 and LEDs 000 indefinitely; set duration2=5 -> RUN entered in 1 clk, step_o=2, colour2 held for 20 clk, repeating.
REQ-027 During step 0 (duration0=10), write duration0=2 at clk 8 -> step 0 still lasts 40 clk, and the next visit lasts 8 clk.
REQ-028 Only duration1=3 nonzero, SEQ_DONE_IRQ_EN defined -> seq_done_o pulses once per 12 clk; with the macro undefined -> always 0.
REQ-029 Assert WBs_RSTn_i low mid-step 1 for 1 clk -> all outputs 0 asynchronously; after release, RUN restarts at the lowest nonzero step with a full duration.
REQ-030 Clear all durations mid-step 3 (duration3=6) -> step 3 completes its 24 clk, then IDLE with LEDs 000.
